// File: rtl/boa_mem_arbiter.sv
// boa_mem_arbiter: two-master round-robin arbiter sharing one slave, grant held across waits, timeout error
module boa_mem_arbiter #(
    parameter int timeout = 255,
    parameter bit m0_prio = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_re,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_re,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_re,
    output logic [3:0]  s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [15:0] to_lim = 16'(timeout);
    state_t state, state_nx;
    logic own, last, req0, req1, any, win, sel, active, to, fwd, done, err, start;
    logic [15:0] cnt;
    assign req0 = m0_re | (|m0_we);
    assign req1 = m1_re | (|m1_we);
    assign any = req0 | req1;
    assign win = (req0 & req1) ? (m0_prio ? 1'b0 : ~last) : req1;
    assign sel = (state == BUSY) ? own : win;
    assign active = !rst && (state == BUSY || any);
    // The timeout blanking uses only registered state so s_ready never reaches s_*
    assign to = state == BUSY && timeout != 0 && cnt == to_lim;
    assign fwd = active && !to;
    assign done = active && (s_ready || to);
    assign err = done && !s_ready;
    assign start = !rst && state == IDLE && any && !s_ready;
    assign s_re = fwd && (sel ? m1_re : m0_re);
    assign s_we = fwd ? (sel ? m1_we : m0_we) : 4'h0;
    assign s_addr = fwd ? (sel ? m1_addr : m0_addr) : 32'h0;
    assign s_wdata = fwd ? (sel ? m1_wdata : m0_wdata) : 32'h0;
    assign grant = active ? {sel, ~sel} : 2'b00;
    assign m0_ready = done && !sel;
    assign m1_ready = done && sel;
    assign m0_err = err && !sel;
    assign m1_err = err && sel;
    assign m0_rdata = (m0_ready && !err) ? s_rdata : 32'h0;
    assign m1_rdata = (m1_ready && !err) ? s_rdata : 32'h0;
    always_comb begin
        state_nx = state;
        if (start) state_nx = BUSY;
        if (state == BUSY && done) state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own <= 1'b0;
            last <= 1'b1;
            cnt <= 16'h0;
        end else begin
            state <= state_nx;
            if (done) last <= sel;
            if (start) begin
                own <= win;
                cnt <= 16'h1;
            end else if (state == BUSY && !done && cnt != 16'hffff) begin
                cnt <= cnt + 16'h1;
            end
        end
    end
endmodule

// File: doc/boa_mem_arbiter.md
# boa_mem_arbiter

Two-master, one-slave round-robin arbiter that lets the instruction port and the data port of a boa32 CPU share one memory or peripheral target. Examples are a single-ported RAM, or a peripheral bus that both a CPU and a DMA engine must reach. It sits between the masters and a memory mux or block RAM port. It owns grant sequencing, holds the grant across multi-cycle slave waits, and returns a bus error on a slave timeout.

## Interface
Parameters:
- `timeout`, default 255: maximum number of BUSY cycles before the transfer is aborted with an error. 0 disables the timeout.
- `m0_prio`, default 0: when 1, master 0 wins every simultaneous request (fixed priority). When 0, simultaneous requests are resolved round-robin.

Ports. All inputs are sampled on the rising edge of `clk`. Reset is synchronous and active-high on `rst`.
- `clk` in 1: CPU clock.
- `rst` in 1: synchronous reset, active-high.
- `m0_re` in 1: master 0 read request.
- `m0_we` in 4: master 0 byte write strobes.
- `m0_addr` in 32: master 0 address.
- `m0_wdata` in 32: master 0 write data.
- `m0_ready` out 1: transfer done for master 0, one-cycle pulse.
- `m0_rdata` out 32: master 0 read data, valid only while `m0_ready` is high.
- `m0_err` out 1: high together with `m0_ready` when the transfer timed out.
- `m1_re`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ready`, `m1_rdata`, `m1_err`: same as master 0, for master 1.
- `s_re` out 1: slave read request.
- `s_we` out 4: slave byte write strobes.
- `s_addr` out 32: slave address.
- `s_wdata` out 32: slave write data.
- `s_ready` in 1: slave transfer done.
- `s_rdata` in 32: slave read data.
- `grant` out 2: one-hot owner of the slave, combinational. 00 when no master owns it.

## Operation
- A master requests when `re` is high or `we` is nonzero. The master holds all request signals stable until its `ready` is high.
- FSM states:
  - IDLE: no owner.
  - BUSY: owner latched in register `own`.
- IDLE behaviour:
  - If exactly one master requests, it wins.
  - If both request and `m0_prio`=1, master 0 wins.
  - If both request and `m0_prio`=0, the master that is not `last` wins.
  - The winner's signals go to `s_*` combinationally in the same cycle, and `grant` shows the winner.
  - If `s_ready` is high in that cycle, the transfer completes: winner `ready`=1, `rdata`=`s_rdata`, `last`←winner, state stays IDLE.
  - Otherwise: state←BUSY, `own`←winner, counter←1.
- BUSY behaviour:
  - `s_*` is driven from `own`, and `grant` equals `own`.
  - If `s_ready`=1: owner `ready`=1, `rdata`=`s_rdata`, `last`←`own`, state←IDLE. The other master is not arbitrated in this cycle.
  - Else if `timeout`≠0 and counter==`timeout`: owner `ready`=1, `err`=1, `rdata`=0, all `s_*` forced to 0 in this cycle, `last`←`own`, state←IDLE.
  - Otherwise: counter increments. The counter is 16 bits wide and saturates; it never wraps.
- The non-owner master always sees `ready`=0, `err`=0 and `rdata`=0.
- If the owner drops its request while BUSY, this is a protocol violation. The arbiter keeps `own` and keeps forwarding the owner's current signals until `s_ready` or timeout.
- Reset values: state=IDLE, `last`=1 (so master 0 wins the first tie), counter=0. While `rst` is high, all outputs are 0 and `s_*` are 0.
- Reset in the middle of a transfer drops the transfer. No `ready` is issued for it.

## Timing
- Zero-wait slave (`s_ready` high in the request cycle): the master gets `ready` in the same cycle, latency 0.
- Slave that responds N cycles after the request cycle: master `ready` in cycle N.
- Back-to-back transfers:
  - A master that keeps requesting after its `ready` is arbitrated again in the next cycle.
  - Under continuous contention with `m0_prio`=0, grants strictly alternate M0, M1, M0, …
- Timeout: with no `s_ready`, the error completes in the cycle where counter==`timeout`. That is `timeout` cycles after the request cycle.
- Combinational paths:
  - `s_ready` → `m*_ready`.
  - `m*` request → `s_*` and `grant` while IDLE.
  - There is no combinational path from `s_ready` to `s_*`.

## Test plan
- Reset, then M0 reads 0x40010010 with a 0-wait slave returning 0xDEADBEEF. Required: `s_re`=1 and `s_addr`=0x40010010 in the same cycle, `m0_ready`=1, `m0_rdata`=0xDEADBEEF, `m1_ready`=0.
- Both masters request in the same cycle; slave has 2 wait states; `m0_prio`=0. Required: M0 is granted first and gets `m0_ready` 2 cycles later. M1 is granted in the following cycle and gets `m1_ready` 2 cycles after that. `grant` sequence: 01, 01, 01, 10, 10, 10.
- Both masters hold requests continuously for 8 transfers with a 0-wait slave. Required: `grant` alternates 01/10 every cycle with `m0_prio`=0, and stays 01 for all 8 cycles with `m0_prio`=1.
- `timeout`=4 and the slave never asserts ready; M1 writes `we`=0xF. Required: `m1_ready`=1 and `m1_err`=1 exactly 4 cycles after the request, `s_we`=0 in that cycle, state is IDLE in the next cycle.
- Assert `rst` for one cycle while M0 is BUSY at wait cycle 2. Required: no `m0_ready`, all outputs 0 during reset. After reset, a simultaneous request is granted to M0.
- M1 drops `m1_re` while BUSY. Required: `grant` stays 10 until `s_ready`, then a single `m1_ready` pulse.
